sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: data bits per frame, >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a frame.
REQ-006 serial_in  input  1  serial data bit.
REQ-007 bit_en  input  1  serial bit strobe; serial_in is sampled only when bit_en=1.
REQ-008 word_ready  input  1  consumer accepts word_out when word_valid=1.
REQ-009 clr_ovr  input  1  clears the overrun flag.
REQ-010 word_out  output  WIDTH  last completed frame, registered.
REQ-011 word_valid  output  1  word_out holds an unconsumed frame.
REQ-012 busy  output  1  frame reception in progress (state != IDLE).
REQ-013 overrun  output  1  sticky: a completed frame was dropped.
REQ-014 parity_err  output  1  present only with SIPO_PARITY_EN; qualifies word_out.

Function
REQ-015 FSM states: IDLE, SHIFT, PARITY (PARITY exists only with SIPO_PARITY_EN).
REQ-016 IDLE: start=1 -> SHIFT and bit_cnt cleared; bit_en in the same cycle is not sampled.
REQ-017 SHIFT: bit_en=1 shifts serial_in into the shift register and increments bit_cnt; bit_en=0 holds all state.
REQ-018 MSB_FIRST=1 shifts left with serial_in entering bit 0; MSB_FIRST=0 shifts right with serial_in entering bit WIDTH-1.
REQ-019 SHIFT, bit_en=1 with bit_cnt==WIDTH-1 completes the data phase: -> PARITY if enabled, else frame completion and -> IDLE.
REQ-020 Frame completion: if word_valid==0, or word_valid==1 and word_ready==1 in that cycle, word_out loads the frame and word_valid=1 from the next cycle.
REQ-021 Frame completion with word_valid==1 and word_ready==0: the frame is dropped, word_out is unchanged, and overrun sets to 1.
REQ-022 word_valid clears on a cycle with word_ready=1 unless a frame completes in that same cycle.
REQ-023 start while busy is ignored.
REQ-024 clr_ovr=1 clears overrun; a simultaneous overrun event takes priority and overrun stays 1.
REQ-025 bit_cnt width is $clog2(WIDTH); it never exceeds WIDTH-1.

Reset
REQ-026 While rst=0 at a clock edge: state=IDLE, bit_cnt=0, shift register=0, word_out=0, word_valid=0, overrun=0, parity_err=0.
REQ-027 Reset mid-frame discards the partial frame; no word_valid pulse results.

Configuration
REQ-028 Macro SIPO_PARITY_EN defined: after the WIDTH data bits, the next bit_en in PARITY samples an even-parity bit, completion occurs then, and parity_err = (XOR of data bits) XOR (parity bit), loaded together with word_out.
REQ-029 SIPO_PARITY_EN undefined: no PARITY state, no parity_err port, and a frame is exactly WIDTH bits.

Structure
REQ-030 Package sipo_ctrl_pkg holds the FSM state typedef and the state encoding constants.
REQ-031 Sub-module sipo_shift holds the enabled, parameterized shift register (WIDTH, MSB_FIRST); sipo_frame_ctrl holds the FSM, counter, output register and flags.

Verification (WIDTH=4 unless stated)
REQ-032 Reset: rst=0 for 2 cycles -> word_out=0, word_valid=0, busy=0, overrun=0.
REQ-033 start, then bits 1,0,1,1 with bit_en every cycle and word_ready=1 -> word_out=4'b1011, word_valid=1 on the cycle after the 4th bit, busy=0 on that cycle.
REQ-034 Same stimulus with MSB_FIRST=0 -> word_out=4'b1101.
REQ-035 bit_en low for 3 cycles between each bit while serial_in toggles freely -> word_out=4'b1011.
REQ-036 word_ready=0, frames 1011 then 0110 -> word_out stays 4'b1011 and overrun=1; clr_ovr pulse -> overrun=0.
REQ-037 rst=0 after 2 bits, then a new frame 0110 -> word_out=4'b0110 with no earlier word_valid; with SIPO_PARITY_EN: frame 1011 with parity 1 -> parity_err=0, with parity 0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared FSM state type and encodings for the SIPO frame controller.
// Build option: SIPO_PARITY_EN adds a trailing even-parity bit per frame.
package sipo_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_PARITY = 2'd2;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Word output handshake of the SIPO frame controller (producer = master).
// Build option: SIPO_PARITY_EN adds parity_err alongside word_out.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  // Handshake: the producer holds word_out stable while word_valid=1; a frame
  // is consumed on any rising edge where word_valid=1 and word_ready=1.
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
`ifdef SIPO_PARITY_EN
  logic             parity_err;

  modport master (output word_out, output word_valid, output parity_err, input word_ready);
  modport slave  (input word_out, input word_valid, input parity_err, output word_ready);
`else
  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
`endif
endinterface

// File: rtl/sipo_shift.sv
// Enabled serial-in shift register; frame exposes either the post-shift value
// (TAP_NEXT=1, word completes on the shifting edge) or the stored value.
module sipo_shift #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit TAP_NEXT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] frame
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;

  // MSB-first shifts left so the first bit ends in the top position.
  always_comb begin
    if (MSB_FIRST) q_next = {q[WIDTH-2:0], din};
    else           q_next = {din, q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (en) q <= q_next;
  end

  assign frame = TAP_NEXT ? q_next : q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// SIPO frame controller: start-triggered frame capture, registered word
// handshake with overrun flag. Build option: SIPO_PARITY_EN.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   serial_in,
  input  logic   bit_en,
  input  logic   clr_ovr,
  output logic   busy,
  output logic   overrun,
  output state_t fsm_state,
  sipo_frame_ctrl_if.master word_bus
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] frame_word;
  logic             shift_en;
  logic             last_bit;
  logic             complete;
  logic             accept;
  logic             drop;

  assign shift_en = (state == ST_SHIFT) && bit_en;
  assign last_bit = (bit_cnt == LAST);

  sipo_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .TAP_NEXT  (!PARITY_EN)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .en    (shift_en),
    .din   (serial_in),
    .frame (frame_word)
  );

`ifdef SIPO_PARITY_EN
  assign complete = (state == ST_PARITY) && bit_en;
`else
  assign complete = shift_en && last_bit;
`endif

  assign accept = complete && (!word_bus.word_valid || word_bus.word_ready);
  assign drop   = complete && word_bus.word_valid && !word_bus.word_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (bit_en) begin
            if (last_bit) begin
              state   <= PARITY_EN ? ST_PARITY : ST_IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef SIPO_PARITY_EN
        ST_PARITY: begin
          if (bit_en) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A completing frame wins over consumption, so valid stays set then.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_bus.word_out   <= '0;
      word_bus.word_valid <= 1'b0;
    end else if (accept) begin
      word_bus.word_out   <= frame_word;
      word_bus.word_valid <= 1'b1;
    end else if (word_bus.word_ready) begin
      word_bus.word_valid <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst)        word_bus.parity_err <= 1'b0;
    else if (accept) word_bus.parity_err <= (^frame_word) ^ serial_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst)         overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a bit-queue frame model.
module tb_sipo_frame_ctrl;
  import sipo_ctrl_pkg::*;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FRAME_BITS = W + 1;
`else
  localparam int FRAME_BITS = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic serial_in = 1'b0;
  logic bit_en = 1'b0;
  logic clr_ovr = 1'b0;
  logic word_ready = 1'b0;
  logic busy_m, busy_l, ovr_m, ovr_l;
  state_t state_m, state_l;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit check_en  = 1'b0;

  sipo_frame_ctrl_if #(.WIDTH(W)) bus_m ();
  sipo_frame_ctrl_if #(.WIDTH(W)) bus_l ();
  assign bus_m.word_ready = word_ready;
  assign bus_l.word_ready = word_ready;

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .rst(rst), .start(start), .serial_in(serial_in), .bit_en(bit_en),
    .clr_ovr(clr_ovr), .busy(busy_m), .overrun(ovr_m), .fsm_state(state_m),
    .word_bus(bus_m)
  );

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_l (
    .clk(clk), .rst(rst), .start(start), .serial_in(serial_in), .bit_en(bit_en),
    .clr_ovr(clr_ovr), .busy(busy_l), .overrun(ovr_l), .fsm_state(state_l),
    .word_bus(bus_l)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  bit         exp_q[$];
  logic [W-1:0] m_word_m = '0;
  logic [W-1:0] m_word_l = '0;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_busy  = 1'b0;

  always @(posedge clk) begin
    bit done, dropped;
    done = 1'b0;
    dropped = 1'b0;
    if (!rst) begin
      exp_q.delete();
      m_busy = 1'b0; m_word_m = '0; m_word_l = '0;
      m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          exp_q.delete();
        end
      end else if (bit_en) begin
        exp_q.push_back(serial_in);
        if (exp_q.size() == FRAME_BITS) begin
          done = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (done) begin
        if (!m_valid || word_ready) begin
          m_perr = 1'b0;
          for (int i = 0; i < W; i++) begin
            m_word_m[W-1-i] = exp_q[i];
            m_word_l[i]     = exp_q[i];
          end
          for (int i = 0; i < FRAME_BITS; i++) m_perr = m_perr ^ exp_q[i];
          m_valid = 1'b1;
        end else begin
          dropped = 1'b1;
          m_ovr = 1'b1;
        end
      end else if (word_ready) begin
        m_valid = 1'b0;
      end
      if (clr_ovr && !dropped) m_ovr = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc word_m",  32'(bus_m.word_out),   32'(m_word_m));
      check("cyc word_l",  32'(bus_l.word_out),   32'(m_word_l));
      check("cyc valid_m", 32'(bus_m.word_valid), 32'(m_valid));
      check("cyc valid_l", 32'(bus_l.word_valid), 32'(m_valid));
      check("cyc busy_m",  32'(busy_m),           32'(m_busy));
      check("cyc busy_l",  32'(busy_l),           32'(m_busy));
      check("cyc ovr_m",   32'(ovr_m),            32'(m_ovr));
      check("cyc ovr_l",   32'(ovr_l),            32'(m_ovr));
`ifdef SIPO_PARITY_EN
      check("cyc perr_m",  32'(bus_m.parity_err), 32'(m_perr));
      check("cyc perr_l",  32'(bus_l.parity_err), 32'(m_perr));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic en, input logic sin,
                       input logic clr, input logic rdy);
    @(negedge clk);
    start = s; bit_en = en; serial_in = sin; clr_ovr = clr; word_ready = rdy;
  endtask

  // Sends v MSB-first in time, then the parity bit when enabled. Ends on the
  // negedge right after the completing edge.
  task automatic send_frame(input logic [W-1:0] v, input int gap, input logic par,
                            input logic restart, input logic rdy_body,
                            input logic rdy_last, input logic clr_last);
    drive(1'b1, 1'b0, 1'b0, 1'b0, rdy_body);
    for (int i = 0; i < FRAME_BITS; i++) begin
      logic b;
      logic last;
      if (i < W) b = v[W-1-i];
      else       b = par;
      last = (i == FRAME_BITS - 1);
      for (int g = 0; g < gap; g++)
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, rdy_body);
      drive(restart && (i == 1), 1'b1, b, last ? clr_last : 1'b0,
            last ? rdy_last : rdy_body);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, rdy_body);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    check("rst word_m",  32'(bus_m.word_out),   32'h0);
    check("rst valid_m", 32'(bus_m.word_valid), 32'h0);
    check("rst busy_m",  32'(busy_m),           32'h0);
    check("rst ovr_m",   32'(ovr_m),            32'h0);
    check("rst state_m", 32'(state_m),          32'(ST_IDLE));
    rst = 1'b1;
    idle(1, 1'b1);

    // basic frame, bit_en every cycle
    send_frame(4'b1011, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("basic word_m",  32'(bus_m.word_out),   32'hB);
    check("basic word_l",  32'(bus_l.word_out),   32'hD);
    check("basic valid_m", 32'(bus_m.word_valid), 32'h1);
    check("basic busy_m",  32'(busy_m),           32'h0);
`ifdef SIPO_PARITY_EN
    check("parity ok",     32'(bus_m.parity_err), 32'h0);
`endif
    idle(2, 1'b1);

    // gaps of 3 idle cycles with serial_in toggling
    send_frame(4'b1011, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("gap word_m", 32'(bus_m.word_out), 32'hB);
    check("gap word_l", 32'(bus_l.word_out), 32'hD);
    idle(2, 1'b1);

    // overrun: second frame dropped while first unconsumed
    send_frame(4'b1011, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr word_m", 32'(bus_m.word_out), 32'hB);
    check("ovr word_l", 32'(bus_l.word_out), 32'hD);
    check("ovr flag_m", 32'(ovr_m),          32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr flag_m", 32'(ovr_m), 32'h0);

    // drop coinciding with clr_ovr keeps overrun set
    send_frame(4'b1100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("drop+clr ovr_m", 32'(ovr_m),          32'h1);
    check("drop+clr word",  32'(bus_m.word_out), 32'hB);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // completion with ready in the same cycle replaces the pending word
    send_frame(4'b0011, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("swap word_m",  32'(bus_m.word_out),   32'h3);
    check("swap word_l",  32'(bus_l.word_out),   32'hC);
    check("swap valid_m", 32'(bus_m.word_valid), 32'h1);
    check("swap ovr_m",   32'(ovr_m),            32'h0);
    idle(2, 1'b1);

    // start while busy is ignored
    send_frame(4'b1001, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("restart word_m", 32'(bus_m.word_out), 32'h9);
    idle(2, 1'b1);

    // reset mid-frame discards partial data
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; bit_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst busy_m",  32'(busy_m),           32'h0);
    check("midrst valid_m", 32'(bus_m.word_valid), 32'h0);
    check("midrst word_m",  32'(bus_m.word_out),   32'h0);
    send_frame(4'b0110, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("postrst word_m", 32'(bus_m.word_out), 32'h6);
    check("postrst word_l", 32'(bus_l.word_out), 32'h6);
    idle(2, 1'b1);

`ifdef SIPO_PARITY_EN
    send_frame(4'b1011, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("parity bad", 32'(bus_m.parity_err), 32'h1);
    idle(2, 1'b1);
`endif

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
